// File: rtl/router_pkg.sv
// Shared configuration for the ant-colony mesh router: mesh geometry, queue
// and pheromone sizing, packet layout and small coordinate helpers.
package router_pkg;

  localparam int N                 = 5;   // input ports
  localparam int M                 = 5;   // output ports
  localparam int X_NODES           = 4;
  localparam int Y_NODES           = 4;
  localparam int NODES             = X_NODES * Y_NODES;
  localparam int INPUT_QUEUE_DEPTH = 4;
  localparam int PH_TABLE_DEPTH    = 4;   // pheromone counter width
  localparam int CREATE_ANT_PERIOD = 64;

  localparam int XW        = 2;
  localparam int YW        = 2;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 8;           // ant path memory, covers the longest minimal path
  localparam int MEMW      = 4;
  localparam int MIW       = 3;

  localparam logic [PH_TABLE_DEPTH-1:0] PH_MAX = '1;
  localparam logic [PH_TABLE_DEPTH-1:0] PH_MIN = {{(PH_TABLE_DEPTH-1){1'b0}}, 1'b1};
  localparam logic [PH_TABLE_DEPTH-1:0] PH_MID = {1'b1, {(PH_TABLE_DEPTH-1){1'b0}}};

  typedef enum logic [2:0] {
    P_LOCAL = 3'd0,
    P_NORTH = 3'd1,
    P_EAST  = 3'd2,
    P_SOUTH = 3'd3,
    P_WEST  = 3'd4
  } port_e;

  typedef struct packed {
    logic [DATA_W-1:0]              data;
    logic [XW-1:0]                  x_dest;
    logic [YW-1:0]                  y_dest;
    logic [XW-1:0]                  x_source;
    logic [YW-1:0]                  y_source;
    logic                           ant;
    logic                           backward;
    logic [MEMW-1:0]                num_memories;
    logic [MEM_DEPTH-1:0][XW-1:0]   x_memory;
    logic [MEM_DEPTH-1:0][YW-1:0]   y_memory;
    logic [MEMW-1:0]                b_num_memories;
    logic [MEM_DEPTH-1:0][XW-1:0]   b_x_memory;
    logic [MEM_DEPTH-1:0][YW-1:0]   b_y_memory;
  } packet_t;

  // Port that moves one step from (hx,hy) toward (tx,ty), x resolved first.
  function automatic port_e toward(input logic [XW-1:0] hx, input logic [YW-1:0] hy,
                                   input logic [XW-1:0] tx, input logic [YW-1:0] ty);
    if (tx > hx) return P_EAST;
    if (tx < hx) return P_WEST;
    if (ty > hy) return P_NORTH;
    if (ty < hy) return P_SOUTH;
    return P_LOCAL;
  endfunction

  function automatic int node_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return int'(y) * X_NODES + int'(x);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Input queue for one router port. A push while full is accepted only when
// the head leaves in the same cycle; otherwise it is dropped.
module fifo_packet
  import router_pkg::*;
#(
  parameter int DEPTH = INPUT_QUEUE_DEPTH
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push_i,
  input  logic    pop_i,
  input  packet_t data_i,
  output packet_t data_o,
  output logic    empty_o,
  output logic    full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

  packet_t       mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_FULL);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Storage array, no reset needed: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/router.sv
// 5-port mesh router with ant-colony adaptive routing: input queues, per-head
// route/ant rewrite, round-robin switch allocation and a registered crossbar.
module router
  import router_pkg::*;
#(
  parameter int X_LOC = 1,
  parameter int Y_LOC = 1
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  packet_t [N-1:0]                              i_data,
  input  logic [N-1:0]                                 i_data_val,
  output logic [N-1:0]                                 o_en,
  output packet_t [M-1:0]                              o_data,
  output logic [M-1:0]                                 o_data_val,
  input  logic [M-1:0]                                 i_en,
  output logic [N-1:0]                                 test_en_SCtoFF,
  output packet_t [N-1:0]                              test_data_FFtoAA,
  output logic [N-1:0]                                 test_data_val_FFtoAA,
  output packet_t [N-1:0]                              test_data_AAtoSW,
  output logic [N-1:0]                                 test_data_val_AAtoRC,
  output logic [N-1:0][M-1:0]                          test_output_req_AAtoSC,
  output logic [N-1:0][M-1:0]                          test_l_req_matrix_SC,
  output logic [N-1:0]                                 test_routing_calculate,
  output logic [N-1:0]                                 test_update,
  output logic [N-1:0]                                 test_select_neighbor,
  output logic [N-1:0][M-1:0]                          test_tb_o_output_req,
  output logic [NODES-1:0][N-2:0][PH_TABLE_DEPTH-1:0]  test_pheromones,
  output logic [PH_TABLE_DEPTH-1:0]                    test_max_pheromone_value,
  output logic [PH_TABLE_DEPTH-1:0]                    test_min_pheromone_value,
  output logic [N-1:0][M-1:0][1:0]                     test_avail_directions
);

  localparam logic [XW-1:0] XL = XW'(X_LOC);
  localparam logic [YW-1:0] YL = YW'(Y_LOC);

  packet_t [N-1:0]      ff_data, rw_data;
  logic [N-1:0]         ff_empty, ff_full, ff_val, pop;
  logic [N-1:0][2:0]    dir;
  logic [N-1:0]         upd, sel_nb;
  logic [N-1:0][M-1:0]  req, mreq, gnt;
  logic [M-1:0][2:0]    win;
  logic [M-1:0]         won;
  logic [M-1:0][2:0]    rr_q;
  packet_t [M-1:0]      odata_q;
  logic [M-1:0]         oval_q;
  logic [NODES-1:0][N-2:0][PH_TABLE_DEPTH-1:0] ph_q, ph_d;

  for (genvar g = 0; g < N; g++) begin : g_ff
    fifo_packet #(.DEPTH(INPUT_QUEUE_DEPTH)) u_ff (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (i_data_val[g]),
      .pop_i   (pop[g]),
      .data_i  (i_data[g]),
      .data_o  (ff_data[g]),
      .empty_o (ff_empty[g]),
      .full_o  (ff_full[g])
    );
  end

  assign ff_val = ~ff_empty;
  assign o_en   = ~ff_full;

  // Route each queue head and produce the ant-field rewrite it leaves with.
  always_comb begin
    packet_t h;
    logic    at_dest, found;
    logic [PH_TABLE_DEPTH-1:0] best;
    logic [MIW-1:0] top;
    int nd;
    rw_data = '0; dir = '0; upd = '0; sel_nb = '0;
    h = '0; at_dest = 1'b0; found = 1'b0; best = '0; top = '0; nd = 0;
    for (int i = 0; i < N; i++) begin
      h          = ff_data[i];
      rw_data[i] = h;
      at_dest    = (h.x_dest == XL) && (h.y_dest == YL);
      if (!h.ant) begin
        dir[i] = toward(XL, YL, h.x_dest, h.y_dest);
      end else if (!h.backward && !at_dest) begin
        // Forward ant: strongest pheromone among minimal directions, lowest port on tie.
        sel_nb[i] = 1'b1;
        nd    = node_idx(h.x_dest, h.y_dest);
        found = 1'b0;
        best  = '0;
        for (int d = 1; d < N; d++) begin
          if (((d == 1 && h.y_dest > YL) || (d == 2 && h.x_dest > XL) ||
               (d == 3 && h.y_dest < YL) || (d == 4 && h.x_dest < XL)) &&
              (!found || ph_q[nd][d-1] > best)) begin
            found  = 1'b1;
            best   = ph_q[nd][d-1];
            dir[i] = 3'(d);
          end
        end
        if (h.num_memories < MEMW'(MEM_DEPTH)) begin
          rw_data[i].x_memory[h.num_memories[MIW-1:0]] = XL;
          rw_data[i].y_memory[h.num_memories[MIW-1:0]] = YL;
          rw_data[i].num_memories = h.num_memories + 1'b1;
        end
      end else if (!h.backward) begin
        // Forward ant at its destination turns around along its own path.
        if (h.num_memories == '0) begin
          dir[i] = P_LOCAL;
        end else begin
          top = MIW'(h.num_memories - 1'b1);
          rw_data[i].backward       = 1'b1;
          rw_data[i].b_x_memory     = h.x_memory;
          rw_data[i].b_y_memory     = h.y_memory;
          rw_data[i].b_num_memories = h.num_memories - 1'b1;
          dir[i] = toward(XL, YL, h.x_memory[top], h.y_memory[top]);
        end
      end else begin
        // Backward ant: reinforce its arrival port, then retrace or exit at source.
        upd[i] = (i != 0);
        if (((h.x_source == XL) && (h.y_source == YL)) || h.b_num_memories == '0) begin
          dir[i] = P_LOCAL;
        end else begin
          top = MIW'(h.b_num_memories - 1'b1);
          rw_data[i].b_num_memories = h.b_num_memories - 1'b1;
          dir[i] = toward(XL, YL, h.b_x_memory[top], h.b_y_memory[top]);
        end
      end
    end
  end

  // One-hot output request per valid head, masked by downstream readiness.
  always_comb begin
    req  = '0;
    mreq = '0;
    for (int i = 0; i < N; i++) begin
      if (ff_val[i]) req[i][dir[i]] = 1'b1;
      mreq[i] = req[i] & i_en;
    end
  end

  // Per-output round-robin starting at rr_q; each input requests one output.
  always_comb begin
    int k;
    gnt = '0; win = '0; won = '0; k = 0;
    for (int o = 0; o < M; o++) begin
      for (int j = 0; j < N; j++) begin
        k = int'(rr_q[o]) + j;
        if (k >= N) k = k - N;
        if (!won[o] && mreq[k][o]) begin
          won[o]    = 1'b1;
          win[o]    = 3'(k);
          gnt[k][o] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) pop[i] = |gnt[i];
  end

  // Pheromone reinforcement for every granted backward ant, saturating.
  always_comb begin
    int sn;
    ph_d = ph_q;
    sn   = 0;
    for (int i = 1; i < N; i++) begin
      if (upd[i] && pop[i]) begin
        sn = node_idx(ff_data[i].x_source, ff_data[i].y_source);
        for (int d = 0; d < N-1; d++) begin
          if (d == i-1) begin
            if (ph_d[sn][d] != PH_MAX) ph_d[sn][d] = ph_d[sn][d] + 1'b1;
          end else begin
            if (ph_d[sn][d] != PH_MIN) ph_d[sn][d] = ph_d[sn][d] - 1'b1;
          end
        end
      end
    end
  end

  // Registered crossbar, round-robin pointers and the pheromone table.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q    <= '0;
      oval_q  <= '0;
      odata_q <= '0;
      ph_q    <= {(NODES*(N-1)){PH_MID}};
    end else begin
      ph_q <= ph_d;
      for (int o = 0; o < M; o++) begin
        oval_q[o] <= won[o];
        if (won[o]) begin
          odata_q[o] <= rw_data[win[o]];
          rr_q[o]    <= (win[o] == 3'(N-1)) ? 3'd0 : win[o] + 3'd1;
        end
      end
    end
  end

  assign o_data     = odata_q;
  assign o_data_val = oval_q;

  assign test_en_SCtoFF           = pop;
  assign test_data_FFtoAA         = ff_data;
  assign test_data_val_FFtoAA     = ff_val;
  assign test_data_AAtoSW         = rw_data;
  assign test_data_val_AAtoRC     = ff_val;
  assign test_output_req_AAtoSC   = req;
  assign test_l_req_matrix_SC     = mreq;
  assign test_routing_calculate   = ff_val;
  assign test_update              = upd & ff_val;
  assign test_select_neighbor     = sel_nb & ff_val;
  assign test_tb_o_output_req     = gnt;
  assign test_pheromones          = ph_q;
  assign test_max_pheromone_value = PH_MAX;
  assign test_min_pheromone_value = PH_MIN;

  // Debug view of each input/output pair: {downstream ready, requested}.
  always_comb begin
    for (int i = 0; i < N; i++)
      for (int o = 0; o < M; o++)
        test_avail_directions[i][o] = {i_en[o], req[i][o]};
  end

endmodule

// File: tb/tb_router.sv
// Self-checking bench for router at (1,1) with a behavioural routing and
// pheromone model.
`timescale 1ns/1ps
module tb_router;
  import router_pkg::*;

  localparam int HX   = 1;
  localparam int HY   = 1;
  localparam int PMAX = 2**PH_TABLE_DEPTH - 1;
  localparam int PMID = 2**(PH_TABLE_DEPTH-1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  packet_t [N-1:0]     i_data = '0;
  logic [N-1:0]        i_data_val = '0;
  logic [N-1:0]        o_en;
  packet_t [M-1:0]     o_data;
  logic [M-1:0]        o_data_val;
  logic [M-1:0]        i_en = '1;
  logic [N-1:0]        t_en_sc, t_val_ff, t_val_aa, t_rc, t_upd, t_sel;
  packet_t [N-1:0]     t_ff, t_aa;
  logic [N-1:0][M-1:0] t_req, t_lreq, t_gnt;
  logic [NODES-1:0][N-2:0][PH_TABLE_DEPTH-1:0] t_ph;
  logic [PH_TABLE_DEPTH-1:0] t_max, t_min;
  logic [N-1:0][M-1:0][1:0]  t_avail;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ph_m [NODES][N-1];

  router #(.X_LOC(HX), .Y_LOC(HY)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
    .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en),
    .test_en_SCtoFF(t_en_sc), .test_data_FFtoAA(t_ff), .test_data_val_FFtoAA(t_val_ff),
    .test_data_AAtoSW(t_aa), .test_data_val_AAtoRC(t_val_aa),
    .test_output_req_AAtoSC(t_req), .test_l_req_matrix_SC(t_lreq),
    .test_routing_calculate(t_rc), .test_update(t_upd), .test_select_neighbor(t_sel),
    .test_tb_o_output_req(t_gnt), .test_pheromones(t_ph),
    .test_max_pheromone_value(t_max), .test_min_pheromone_value(t_min),
    .test_avail_directions(t_avail)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int xy_port(int xd, int yd);
    if (xd > HX) return 2;
    if (xd < HX) return 4;
    if (yd > HY) return 1;
    if (yd < HY) return 3;
    return 0;
  endfunction

  function automatic int ant_port(int xd, int yd);
    int best = -1;
    int bp = 0;
    int node = xd + yd * X_NODES;
    bit cand [1:4];
    cand[1] = yd > HY; cand[2] = xd > HX; cand[3] = yd < HY; cand[4] = xd < HX;
    for (int d = 1; d <= 4; d++)
      if (cand[d] && ph_m[node][d-1] > best) begin best = ph_m[node][d-1]; bp = d; end
    return bp;
  endfunction

  function automatic void ph_reinforce(int node, int arr);
    for (int d = 0; d < N-1; d++) begin
      if (d == arr-1) ph_m[node][d] = (ph_m[node][d] + 1 > PMAX) ? PMAX : ph_m[node][d] + 1;
      else            ph_m[node][d] = (ph_m[node][d] - 1 < 1) ? 1 : ph_m[node][d] - 1;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; i_data_val = '0; i_en = '1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < NODES; n++)
      for (int d = 0; d < N-1; d++) ph_m[n][d] = PMID;
  endtask

  task automatic inject(input int port, input packet_t p);
    i_data[port] = p;
    i_data_val[port] = 1'b1;
    @(negedge clk);
    i_data_val = '0;
  endtask

  task automatic wait_out(output int port, output packet_t p);
    port = -1;
    p = '0;
    for (int c = 0; c < 8 && port < 0; c++) begin
      @(negedge clk);
      for (int o = M-1; o >= 0; o--) if (o_data_val[o]) port = o;
      if (port >= 0) p = o_data[port];
    end
  endtask

  function automatic packet_t rand_data(int xd, int yd);
    packet_t p = '0;
    p.data = 16'($urandom());
    p.x_dest = 2'(xd); p.y_dest = 2'(yd);
    p.x_source = 2'($urandom_range(0, 3)); p.y_source = 2'($urandom_range(0, 3));
    return p;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ok = 1;
    do_reset();
    total_cnt++; if (o_data_val !== 5'b00000) $display("FAIL reset_oval got=%b exp=00000", o_data_val); else pass_cnt++;
    total_cnt++; if (o_en !== 5'b11111) $display("FAIL reset_oen got=%b exp=11111", o_en); else pass_cnt++;
    for (int n = 0; n < NODES; n++)
      for (int d = 0; d < N-1; d++) if (t_ph[n][d] !== PH_TABLE_DEPTH'(PMID)) ok = 0;
    total_cnt++; if (!ok) $display("FAIL reset_pheromones got=%h exp all %0d", t_ph, PMID); else pass_cnt++;
    total_cnt++; if (t_max !== PH_TABLE_DEPTH'(PMAX)) $display("FAIL ph_max got=%0d exp=%0d", t_max, PMAX); else pass_cnt++;
    total_cnt++; if (t_min !== PH_TABLE_DEPTH'(1)) $display("FAIL ph_min got=%0d exp=1", t_min); else pass_cnt++;
  endtask

  task automatic test_local_delivery();
    packet_t p = rand_data(HX, HY);
    i_data[2] = p; i_data_val[2] = 1'b1;
    @(negedge clk);
    i_data_val = '0;
    total_cnt++; if (o_data_val !== 5'b00000) $display("FAIL local_early got=%b exp=00000", o_data_val); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (o_data_val !== 5'b00001) $display("FAIL local_val got=%b exp=00001", o_data_val); else pass_cnt++;
    total_cnt++; if (o_data[0] !== p) $display("FAIL local_data got=%h exp=%h", o_data[0], p); else pass_cnt++;
  endtask

  task automatic test_xy_routing();
    int dx [3] = '{3, 1, 0};
    int dy [3] = '{0, 3, 1};
    int ep [3] = '{2, 1, 4};
    int port, src, xd, yd, exp_port;
    packet_t p, q;
    for (int k = 0; k < 3 + 24; k++) begin
      if (k < 3) begin
        src = 0; xd = dx[k]; yd = dy[k]; exp_port = ep[k];
      end else begin
        src = $urandom_range(0, 4); xd = $urandom_range(0, 3); yd = $urandom_range(0, 3);
        exp_port = xy_port(xd, yd);
      end
      p = rand_data(xd, yd);
      inject(src, p);
      wait_out(port, q);
      total_cnt++; if (port !== exp_port) $display("FAIL xy_port dest=(%0d,%0d) got=%0d exp=%0d", xd, yd, port, exp_port); else pass_cnt++;
      total_cnt++; if (q !== p) $display("FAIL xy_data got=%h exp=%h", q, p); else pass_cnt++;
    end
  endtask

  task automatic test_contention();
    packet_t p [1:3];
    do_reset();
    for (int s = 1; s <= 3; s++) begin
      p[s] = rand_data(HX, HY);
      p[s].data = 16'(16'hC000 + s);
      i_data[s] = p[s];
      i_data_val[s] = 1'b1;
    end
    @(negedge clk);
    i_data_val = '0;
    for (int s = 1; s <= 3; s++) begin
      @(negedge clk);
      total_cnt++; if (o_data_val !== 5'b00001) $display("FAIL contention_val slot=%0d got=%b exp=00001", s, o_data_val); else pass_cnt++;
      total_cnt++; if (o_data[0] !== p[s]) $display("FAIL contention_order slot=%0d got=%h exp=%h", s, o_data[0].data, p[s].data); else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (o_data_val !== 5'b00000) $display("FAIL contention_extra got=%b exp=00000", o_data_val); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    packet_t p;
    int got = 0;
    do_reset();
    i_en[2] = 1'b0;
    for (int k = 0; k < INPUT_QUEUE_DEPTH + 2; k++) begin
      total_cnt++; if (o_en[0] !== (k < INPUT_QUEUE_DEPTH)) $display("FAIL bp_oen push=%0d got=%b exp=%b", k, o_en[0], k < INPUT_QUEUE_DEPTH); else pass_cnt++;
      p = rand_data(3, 1);
      p.data = 16'(16'h0100 + k);
      inject(0, p);
    end
    total_cnt++; if (o_val_any()) $display("FAIL bp_leak got=%b exp=00000", o_data_val); else pass_cnt++;
    i_en = '1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_data_val[2]) begin
        total_cnt++; if (o_data[2].data !== 16'(16'h0100 + got)) $display("FAIL bp_drain_order got=%h exp=%h", o_data[2].data, 16'(16'h0100 + got)); else pass_cnt++;
        got++;
      end
    end
    total_cnt++; if (got !== INPUT_QUEUE_DEPTH) $display("FAIL bp_drain_count got=%0d exp=%0d", got, INPUT_QUEUE_DEPTH); else pass_cnt++;
  endtask

  function automatic bit o_val_any();
    return |o_data_val;
  endfunction

  task automatic check_row(input int node, input string tag);
    logic [N-2:0][PH_TABLE_DEPTH-1:0] er;
    for (int d = 0; d < N-1; d++) er[d] = PH_TABLE_DEPTH'(ph_m[node][d]);
    total_cnt++; if (t_ph[node] !== er) $display("FAIL %s node=%0d got=%h exp=%h", tag, node, t_ph[node], er); else pass_cnt++;
  endtask

  task automatic test_ant_flow();
    packet_t p, q, e;
    int port, xd, yd, nm, arr;
    do_reset();
    // Forward ant, equal pheromones: north wins the tie.
    p = rand_data(3, 3); p.ant = 1'b1;
    inject(0, p); wait_out(port, q);
    e = p; e.num_memories = 4'd1; e.x_memory[0] = 2'(HX); e.y_memory[0] = 2'(HY);
    total_cnt++; if (port !== 1) $display("FAIL fant_tie_port got=%0d exp=1", port); else pass_cnt++;
    total_cnt++; if (q !== e) $display("FAIL fant_push got=%h exp=%h", q, e); else pass_cnt++;
    // Backward ants for source (3,3) arriving from east, retracing to (1,2).
    for (int k = 0; k < 10; k++) begin
      p = rand_data(1, 1); p.ant = 1'b1; p.backward = 1'b1;
      p.x_source = 2'd3; p.y_source = 2'd3;
      p.b_num_memories = 4'd1; p.b_x_memory[0] = 2'd1; p.b_y_memory[0] = 2'd2;
      inject(2, p); wait_out(port, q);
      e = p; e.b_num_memories = 4'd0;
      ph_reinforce(15, 2);
      total_cnt++; if (port !== 1) $display("FAIL bant_port got=%0d exp=1", port); else pass_cnt++;
      total_cnt++; if (q !== e) $display("FAIL bant_pop got=%h exp=%h", q, e); else pass_cnt++;
      check_row(15, "bant_ph");
    end
    // Reinforced east now wins for destination (3,3).
    p = rand_data(3, 3); p.ant = 1'b1;
    inject(0, p); wait_out(port, q);
    total_cnt++; if (port !== ant_port(3, 3)) $display("FAIL fant_pref_port got=%0d exp=%0d", port, ant_port(3, 3)); else pass_cnt++;
    // Forward ant at its destination turns backward toward its last hop (2,1).
    p = rand_data(HX, HY); p.ant = 1'b1; p.num_memories = 4'd2;
    p.x_memory[0] = 2'd3; p.y_memory[0] = 2'd1; p.x_memory[1] = 2'd2; p.y_memory[1] = 2'd1;
    inject(4, p); wait_out(port, q);
    e = p; e.backward = 1'b1; e.b_x_memory = p.x_memory; e.b_y_memory = p.y_memory; e.b_num_memories = 4'd1;
    total_cnt++; if (port !== 2) $display("FAIL fant_turn_port got=%0d exp=2", port); else pass_cnt++;
    total_cnt++; if (q !== e) $display("FAIL fant_turn_data got=%h exp=%h", q, e); else pass_cnt++;
    // Random backward ants home at this node: exit locally, reinforce arrival port.
    for (int k = 0; k < 16; k++) begin
      arr = $urandom_range(1, 4);
      p = rand_data($urandom_range(0, 3), $urandom_range(0, 3)); p.ant = 1'b1; p.backward = 1'b1;
      p.x_source = 2'(HX); p.y_source = 2'(HY); p.b_num_memories = 4'($urandom_range(0, 3));
      inject(arr, p); wait_out(port, q);
      ph_reinforce(HX + HY * X_NODES, arr);
      total_cnt++; if (port !== 0 || q !== p) $display("FAIL bant_home arr=%0d got port=%0d data=%h exp port=0 data=%h", arr, port, q, p); else pass_cnt++;
      check_row(HX + HY * X_NODES, "bant_home_ph");
    end
    // Random forward ants checked against the model table.
    for (int k = 0; k < 12; k++) begin
      do begin xd = $urandom_range(0, 3); yd = $urandom_range(0, 3); end while (xd == HX && yd == HY);
      if (k % 3 == 0) begin xd = 3; yd = 3; end
      nm = $urandom_range(0, 6);
      p = rand_data(xd, yd); p.ant = 1'b1; p.num_memories = 4'(nm);
      p.x_memory = 16'($urandom()); p.y_memory = 16'($urandom());
      inject($urandom_range(0, 4), p); wait_out(port, q);
      e = p; e.num_memories = 4'(nm + 1); e.x_memory[nm] = 2'(HX); e.y_memory[nm] = 2'(HY);
      total_cnt++; if (port !== ant_port(xd, yd)) $display("FAIL fant_rand_port dest=(%0d,%0d) got=%0d exp=%0d", xd, yd, port, ant_port(xd, yd)); else pass_cnt++;
      total_cnt++; if (q !== e) $display("FAIL fant_rand_data got=%h exp=%h", q, e); else pass_cnt++;
    end
  endtask

  task automatic test_reset_flush();
    int seen = 0;
    bit ok = 1;
    i_en = '0;
    for (int k = 0; k < 3; k++) inject(k, rand_data(HX, HY));
    reset_n = 1'b0; i_en = '1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_data_val !== '0) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL flush_outputs got=%0d valid cycles exp=0", seen); else pass_cnt++;
    total_cnt++; if (o_en !== 5'b11111) $display("FAIL flush_oen got=%b exp=11111", o_en); else pass_cnt++;
    for (int n = 0; n < NODES; n++)
      for (int d = 0; d < N-1; d++) if (t_ph[n][d] !== PH_TABLE_DEPTH'(PMID)) ok = 0;
    total_cnt++; if (!ok) $display("FAIL flush_pheromones got=%h exp all %0d", t_ph, PMID); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_local_delivery();
    test_xy_routing();
    test_contention();
    test_backpressure();
    test_ant_flow();
    test_reset_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
